// File: rtl/ram_access_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the burst RAM access controller.
package ram_access_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    RD_HOLD,
    WR_DATA
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request, write-beat and read-beat handshakes between a host and the controller.
interface ram_access_ctrl_if
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, done
  );

endinterface

// File: rtl/ram_access_ctrl.sv
// Burst controller in front of a synchronous single-port RAM: 1..16 word bursts,
// reads at one word per three cycles, writes at one word per cycle.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_access_ctrl_if.slave  bus,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] rdata_r;
  logic              rdata_valid_r;
  logic              done_r;

  assign bus.req_ready   = (state == IDLE);
  assign bus.wdata_ready = (state == WR_DATA);
  assign bus.rdata_valid = rdata_valid_r;
  assign bus.rdata       = rdata_r;
  assign bus.done        = done_r;

  // Write strobe is combinational so an asserted reset kills it immediately.
  assign ram_addr  = cur_addr;
  assign ram_write = (state == WR_DATA) && bus.wdata_valid;
  assign ram_d     = bus.wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      count         <= '0;
      rdata_r       <= '0;
      rdata_valid_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr <= bus.req_addr;
            count    <= bus.req_len;
            state    <= bus.req_write ? WR_DATA : RD_ISSUE;
          end
        end
        RD_ISSUE: state <= RD_CAPT;
        RD_CAPT: begin
          rdata_r       <= ram_q;
          rdata_valid_r <= 1'b1;
          state         <= RD_HOLD;
        end
        RD_HOLD: begin
          if (bus.rdata_ready) begin
            rdata_valid_r <= 1'b0;
            if (count == '0) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              count    <= count - LEN_W'(1);
              state    <= RD_ISSUE;
            end
          end
        end
        // Address wraps naturally at the top of the RAM.
        WR_DATA: begin
          if (bus.wdata_valid) begin
            if (count == '0) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              count    <= count - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural 512x32 synchronous RAM.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int LW = LEN_W_DEF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cycles = 0;
  int rd_seen = 0;
  int n;
  int lat;

  ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM: q reflects the address presented before the edge.
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_write) mem[ram_addr] = ram_d;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_write) wr_cycles++;
      if (bus.done) done_cnt++;
      if (bus.rdata_valid) rd_seen++;
      if (bus.rdata_valid && bus.rdata_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("rd_extra_beat", DW'(exp_q.size()), 32'd1);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("rdata", bus.rdata, exp_word);
        end
      end
    end
  end

  task automatic waitCycles(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("rd_drain", DW'(exp_q.size()), 32'd0);
  endtask

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len, input logic [DW-1:0] d0);
    int k;
    logic [AW-1:0] a;
    if (!wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + AW'(i);
        exp_q.push_back(model[a]);
      end
    end
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("req_accept", DW'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + AW'(i);
        bus.wdata_valid = 1'b1;
        bus.wdata       = d0 + DW'(i);
        model[a]        = d0 + DW'(i);
        @(negedge clk);
        checkOutput("wr_strobe", DW'(ram_write), 32'd1);
        checkOutput("wr_addr", DW'(ram_addr), DW'(a));
        @(posedge clk);
        #1;
      end
      bus.wdata_valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
    mem[104]   = 32'h0000_0055;
    model[104] = 32'h0000_0055;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;
    reset_n = 1'b0;

    #12;
    checkOutput("rst_ram_write", DW'(ram_write), 32'd0);
    checkOutput("rst_rdata_valid", DW'(bus.rdata_valid), 32'd0);
    checkOutput("rst_done", DW'(bus.done), 32'd0);
    checkOutput("rst_ram_addr", DW'(ram_addr), 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", DW'(bus.req_ready), 32'd1);

    // Single-word read with a stray write beat that must be ignored.
    $display("[TB] single-word read at 104");
    done_cnt = 0;
    wr_cycles = 0;
    bus.rdata_ready = 1'b1;
    bus.wdata_valid = 1'b1;
    bus.wdata       = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, AW'(104), LW'(0), '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rdata_valid && lat < 20);
    checkOutput("rd_latency", DW'(lat), 32'd3);
    waitDrain();
    waitCycles(3);
    checkOutput("rd_done_once", DW'(done_cnt), 32'd1);
    checkOutput("stray_wdata", DW'(wr_cycles), 32'd0);
    bus.wdata_valid = 1'b0;

    $display("[TB] wrapping 4-word write at 510");
    done_cnt = 0;
    wr_cycles = 0;
    applyStimulus(1'b1, AW'(510), LW'(3), 32'h0000_00A0);
    waitCycles(2);
    checkOutput("mem510", mem[510], 32'h0000_00A0);
    checkOutput("mem511", mem[511], 32'h0000_00A1);
    checkOutput("mem0", mem[0], 32'h0000_00A2);
    checkOutput("mem1", mem[1], 32'h0000_00A3);
    checkOutput("wr_cycle_count", DW'(wr_cycles), 32'd4);
    checkOutput("wr_done_once", DW'(done_cnt), 32'd1);

    $display("[TB] wrapping read-back with stall on beat 2");
    done_cnt = 0;
    bus.rdata_ready = 1'b1;
    applyStimulus(1'b0, AW'(510), LW'(3), '0);
    n = 0;
    while (exp_q.size() > 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.rdata_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rdata_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_rdata", bus.rdata, 32'h0000_00A1);
      checkOutput("hold_valid", DW'(bus.rdata_valid), 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rdata_ready = 1'b1;
    waitDrain();
    waitCycles(3);
    checkOutput("rd4_done_once", DW'(done_cnt), 32'd1);

    $display("[TB] new request during an active write burst");
    done_cnt = 0;
    rd_seen = 0;
    bus.req_write = 1'b1;
    bus.req_addr  = AW'(20);
    bus.req_len   = LW'(2);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_write = 1'b0;
    bus.req_addr  = AW'(5);
    bus.req_len   = LW'(7);
    repeat (3) begin
      @(negedge clk);
      checkOutput("busy_req_ready", DW'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.req_valid = 1'b0;
      bus.wdata_valid = 1'b1;
      bus.wdata       = 32'h0000_00B0 + DW'(i);
      @(posedge clk);
      #1;
    end
    bus.wdata_valid = 1'b0;
    waitCycles(3);
    checkOutput("mem20", mem[20], 32'h0000_00B0);
    checkOutput("mem21", mem[21], 32'h0000_00B1);
    checkOutput("mem22", mem[22], 32'h0000_00B2);
    checkOutput("busy_done_once", DW'(done_cnt), 32'd1);
    checkOutput("busy_no_read", DW'(rd_seen), 32'd0);
    checkOutput("busy_idle_ready", DW'(bus.req_ready), 32'd1);

    $display("[TB] reset after first beat of a 4-word write");
    for (int i = 0; i < 4; i++) mem[200 + i] = 32'h1111_0000 + DW'(i);
    bus.req_write = 1'b1;
    bus.req_addr  = AW'(200);
    bus.req_len   = LW'(3);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = 32'h0000_00C0;
    @(posedge clk);
    #1;
    bus.wdata = 32'h0000_00C1;
    reset_n   = 1'b0;
    #1;
    checkOutput("rst_mid_strobe", DW'(ram_write), 32'd0);
    checkOutput("rst_mid_addr", DW'(ram_addr), 32'd0);
    waitCycles(2);
    bus.wdata_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready", DW'(bus.req_ready), 32'd1);
    checkOutput("mem200", mem[200], 32'h0000_00C0);
    checkOutput("mem201", mem[201], 32'h1111_0001);
    checkOutput("mem202", mem[202], 32'h1111_0002);
    checkOutput("mem203", mem[203], 32'h1111_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
